// File: rtl/exp2_pkg.sv
// Shared types and constants for the sequential power-of-two generator.
package exp2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } exp2_state_t;

  localparam int EXP2_WIDTH_DEF = 8;

  // Exponent width needed to address every bit of a w-bit word.
  function automatic int exp2_log_w(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/exp2_seq.sv
// Sequential 2**n generator: walks a single set bit left once per clock and
// returns the one-hot word over a valid/ready handshake.
module exp2_seq
  import exp2_pkg::*;
#(
  parameter int WIDTH = EXP2_WIDTH_DEF,
  parameter int LOG_W = exp2_log_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG_W-1:0] in_log,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_number,
  output logic             out_err,
  output logic             busy
);

  localparam logic [LOG_W:0] WIDTH_L = (LOG_W + 1)'(WIDTH);

  exp2_state_t      state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [LOG_W-1:0] cnt;
  logic             err;
  logic             accept;
  logic             out_of_range;

  assign accept       = in_valid & in_ready;
  assign out_of_range = ({1'b0, in_log} >= WIDTH_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (out_of_range || (in_log == '0)) state_nxt = DONE;
          else                                state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // SHIFT is only entered with cnt >= 1, so cnt never wraps.
        if (cnt == LOG_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt <= in_log;
            if (out_of_range) begin
              shreg <= '0;
              err   <= 1'b1;
            end else begin
              shreg <= WIDTH'(1);
              err   <= 1'b0;
            end
          end
        end
        SHIFT: begin
          shreg <= shreg << 1;
          cnt   <= cnt - LOG_W'(1);
        end
        DONE: begin
          if (out_ready) err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_number = shreg;
  assign out_err    = err;

endmodule

// File: tb/tb_exp2_seq.sv
// Directed-vector bench for exp2_seq: an 8-bit instance for normal operation
// and a 6-bit instance for the out-of-range exponent path.
module tb_exp2_seq;

  logic       clk;
  logic       rst;

  logic       in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [2:0] in_log;
  logic [7:0] out_number;

  logic       in_valid6, in_ready6, out_valid6, out_ready6, out_err6, busy6;
  logic [2:0] in_log6;
  logic [5:0] out_number6;

  int vectors;
  int miscompares;
  int cyc;

  exp2_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_log     (in_log),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_number (out_number),
    .out_err    (out_err),
    .busy       (busy)
  );

  exp2_seq #(.WIDTH(6)) dut6 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid6),
    .in_ready   (in_ready6),
    .in_log     (in_log6),
    .out_valid  (out_valid6),
    .out_ready  (out_ready6),
    .out_number (out_number6),
    .out_err    (out_err6),
    .busy       (busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Round-trip reference: index of the highest set bit, -1 for zero.
  function automatic int log2_of(input logic [7:0] x);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (x[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one exponent (block must be idle), then count edges until out_valid.
  task automatic do_req(input logic [2:0] n, output int lat);
    in_log   = n;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_number, out_err, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset8: got rdy=%b vld=%b num=%h err=%b busy=%b, expected 1 0 00 0 0",
               in_ready, out_valid, out_number, out_err, busy);
    end
    vectors++;
    if ({in_ready6, out_valid6, out_number6, out_err6, busy6} !== {1'b1, 1'b0, 6'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset6: got rdy=%b vld=%b num=%h err=%b busy=%b, expected 1 0 00 0 0",
               in_ready6, out_valid6, out_number6, out_err6, busy6);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    do_req(3'd6, lat);
    vectors++;
    if (lat !== 6) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected 6", lat);
    end
    vectors++;
    if (out_number !== 8'b0100_0000 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got num=%b err=%b expected 01000000 err=0", out_number, out_err);
    end
    vectors++;
    if (log2_of(out_number) !== 6) begin
      miscompares++;
      $display("FAIL basic_roundtrip: got %0d expected 6", log2_of(out_number));
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_idle: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_zero();
    int lat;
    out_ready = 1'b0;
    do_req(3'd0, lat);
    vectors++;
    if (lat !== 0 || out_number !== 8'h01) begin
      miscompares++;
      $display("FAIL zero_result: got lat=%0d num=%h expected lat=0 num=01", lat, out_number);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_ready_done: got %b expected 0", in_ready);
    end
    out_ready = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_ready_hs: got %b expected 0", in_ready);
    end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_after_hs: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int acc [8];
    int guard;
    logic [7:0] exp_num;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_log = 3'(i);
      guard = 0;
      while (!in_ready && guard < 40) begin
        tick();
        guard++;
      end
      tick();
      acc[i] = cyc;
      guard = 0;
      while (!out_valid && guard < 40) begin
        tick();
        guard++;
      end
      exp_num = 8'h01 << i;
      vectors++;
      if (out_number !== exp_num || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_num[%0d]: got vld=%b num=%h expected vld=1 num=%h", i, out_valid, out_number, exp_num);
      end
      vectors++;
      if (log2_of(out_number) !== i) begin
        miscompares++;
        $display("FAIL sweep_roundtrip[%0d]: got %0d expected %0d", i, log2_of(out_number), i);
      end
      if (i > 0) begin
        vectors++;
        if (acc[i] - acc[i-1] !== (i - 1) + 2) begin
          miscompares++;
          $display("FAIL sweep_period[%0d]: got %0d expected %0d", i - 1, acc[i] - acc[i-1], i + 1);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    do_req(3'd5, lat);
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("FAIL bp_latency: got %0d expected 5", lat);
    end
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_number !== 8'b0010_0000) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got vld=%b num=%b expected 1 00100000", c, out_valid, out_number);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got vld=%b busy=%b rdy=%b expected 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_out_of_range();
    int guard;
    out_ready6 = 1'b0;
    in_log6    = 3'd6;
    in_valid6  = 1'b1;
    tick();
    in_valid6  = 1'b0;
    vectors++;
    if (out_valid6 !== 1'b1 || out_number6 !== 6'h00 || out_err6 !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_result: got vld=%b num=%h err=%b expected 1 00 1", out_valid6, out_number6, out_err6);
    end
    out_ready6 = 1'b1;
    tick();
    out_ready6 = 1'b0;
    vectors++;
    if (out_err6 !== 1'b0 || out_valid6 !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_clear: got err=%b vld=%b expected 0 0", out_err6, out_valid6);
    end
    in_log6   = 3'd5;
    in_valid6 = 1'b1;
    tick();
    in_valid6 = 1'b0;
    guard = 0;
    while (!out_valid6 && guard < 40) begin
      tick();
      guard++;
    end
    vectors++;
    if (guard !== 5 || out_number6 !== 6'b10_0000 || out_err6 !== 1'b0) begin
      miscompares++;
      $display("FAIL w6_top: got lat=%0d num=%b err=%b expected 5 100000 0", guard, out_number6, out_err6);
    end
    out_ready6 = 1'b1;
    tick();
    out_ready6 = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    out_ready = 1'b0;
    in_log    = 3'd7;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_number, out_err, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset: got rdy=%b vld=%b num=%h err=%b busy=%b, expected 1 0 00 0 0",
               in_ready, out_valid, out_number, out_err, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_discard: got vld=%b busy=%b expected 0 0", out_valid, busy);
    end
    do_req(3'd2, lat);
    vectors++;
    if (lat !== 2 || out_number !== 8'b0000_0100) begin
      miscompares++;
      $display("FAIL mid_next: got lat=%0d num=%b expected 2 00000100", lat, out_number);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_log      = 3'd0;
    out_ready   = 1'b0;
    in_valid6   = 1'b0;
    in_log6     = 3'd0;
    out_ready6  = 1'b0;

    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_shift();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
